// File: rtl/mem_compute.sv
// Lookup-table compute engine: per-lane table read into a single result register.
// Latency: 1 cycle from accept to data_out_valid.
// Backpressure: data_in_ready drops while an unconsumed result is held and data_out_ready is low.
module mem_compute #(
    parameter int    NUM_FN_CALLS  = 4,
    parameter int    FN_CALL_WIDTH = 8,
    parameter int    DATA_WIDTH    = 8,
    parameter string INIT_FILE     = ""
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_FN_CALLS*FN_CALL_WIDTH-1:0] data_in,
    input  logic [NUM_FN_CALLS-1:0]               data_in_valid,
    output logic                                  data_in_ready,
    output logic [NUM_FN_CALLS*DATA_WIDTH-1:0]    data_out,
    output logic                                  data_out_valid,
    input  logic                                  data_out_ready
);

    localparam int DEPTH = 2 ** FN_CALL_WIDTH;
    localparam int LO_W  = FN_CALL_WIDTH / 2;

    // Upper argument bits times lower argument bits, fitted to the result width.
    function automatic logic [DATA_WIDTH-1:0] builtin_entry(input int unsigned x);
        int unsigned hi;
        int unsigned lo;
        int unsigned prod;
        hi   = x >> LO_W;
        lo   = x & ((32'd1 << LO_W) - 32'd1);
        prod = hi * lo;
        return DATA_WIDTH'(prod);
    endfunction

    logic [DATA_WIDTH-1:0] table_mem [DEPTH];

    generate
        for (genvar x = 0; x < DEPTH; x++) begin : g_entry
            assign table_mem[x] = builtin_entry(x);
        end
    endgenerate

    logic [NUM_FN_CALLS*DATA_WIDTH-1:0] lookup;
    logic [NUM_FN_CALLS*DATA_WIDTH-1:0] data_out_d;
    logic [NUM_FN_CALLS*DATA_WIDTH-1:0] data_out_q;
    logic                               data_out_valid_d;
    logic                               data_out_valid_q;
    logic                               accept;

    // Every lane reads the table independently; invalid lanes yield zero.
    always_comb begin
        lookup = '0;
        for (int i = 0; i < NUM_FN_CALLS; i++) begin
            if (data_in_valid[i]) begin
                lookup[i*DATA_WIDTH +: DATA_WIDTH] =
                    table_mem[data_in[i*FN_CALL_WIDTH +: FN_CALL_WIDTH]];
            end
        end
    end

    assign data_in_ready = !rst && (!data_out_valid_q || data_out_ready);
    assign accept        = data_in_ready && (|data_in_valid);

    always_comb begin
        data_out_d       = data_out_q;
        data_out_valid_d = data_out_valid_q;
        if (accept) begin
            data_out_d       = lookup;
            data_out_valid_d = 1'b1;
        end else if (data_out_valid_q && data_out_ready) begin
            data_out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
        end else begin
            data_out_q       <= data_out_d;
            data_out_valid_q <= data_out_valid_d;
        end
    end

    assign data_out       = data_out_q;
    assign data_out_valid = data_out_valid_q;

endmodule

// File: tb/tb_mem_compute.sv
// Scoreboard bench for mem_compute: driver pushes expected results, a negedge monitor pops on consume.
module tb_mem_compute;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_in;
    logic [3:0]  data_in_valid;
    logic        data_in_ready;
    logic [31:0] data_out;
    logic        data_out_valid;
    logic        data_out_ready;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic        model_vld;

    always #5 clk = ~clk;

    mem_compute dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready)
    );

    function automatic logic [7:0] ref_lane(input logic [7:0] a);
        int p;
        p = int'(a[7:4]) * int'(a[3:0]);
        return 8'(p);
    endfunction

    function automatic logic [31:0] ref_xfer(input logic [31:0] d, input logic [3:0] v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++)
            if (v[i]) r[i*8 +: 8] = ref_lane(d[i*8 +: 8]);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus, applied just after a rising edge.
    task automatic drive(input logic [31:0] d, input logic [3:0] v, input logic ordy);
        logic acc;
        @(posedge clk);
        #1;
        data_in        = d;
        data_in_valid  = v;
        data_out_ready = ordy;
        acc = (|v) && (!model_vld || ordy);
        if (acc) exp_q.push_back(ref_xfer(d, v));
        #1;
        check("in_ready", {31'd0, data_in_ready}, {31'd0, (!model_vld || ordy)});
        model_vld = acc ? 1'b1 : (ordy ? 1'b0 : model_vld);
    endtask

    // Monitor: a result is consumed at the edge following a negedge with valid and ready high.
    always @(negedge clk) begin
        if (!rst && data_out_valid && data_out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got %h expected no output at %0t", data_out, $time);
            end else begin
                check("scoreboard", data_out, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] hold_val;
        rst            = 1'b1;
        data_in        = '0;
        data_in_valid  = '0;
        data_out_ready = 1'b0;
        model_vld      = 1'b0;
        #1;
        check("rst_valid", {31'd0, data_out_valid}, 32'd0);
        check("rst_data", data_out, 32'd0);
        check("rst_ready", {31'd0, data_in_ready}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_after_rst", {31'd0, data_in_ready}, 32'd1);

        // Basic transfer with one-cycle latency
        drive(32'h12233445, 4'b1111, 1'b1);
        drive(32'h0, 4'b0000, 1'b1);
        check("basic_valid", {31'd0, data_out_valid}, 32'd1);
        check("basic_data", data_out, 32'h02060C14);

        // Back-to-back transfers
        drive(32'h56677889, 4'b1111, 1'b1);
        drive(32'h9aabbccd, 4'b1111, 1'b1);
        check("b2b_0", data_out, 32'h1E2A3848);
        drive(32'hdeeff001, 4'b1111, 1'b1);
        check("b2b_1", data_out, 32'h5A6E849C);
        drive(32'h0, 4'b0000, 1'b1);
        check("b2b_2", data_out, 32'hB6D20000);

        // Partial lanes
        drive(32'hffffffff, 4'b0101, 1'b1);
        drive(32'h0, 4'b0000, 1'b1);
        check("partial", data_out, 32'h00E100E1);

        // Backpressure: hold for 5 cycles, then release
        drive(32'h3377aa55, 4'b1111, 1'b1);
        hold_val = ref_xfer(32'h3377aa55, 4'b1111);
        for (int k = 0; k < 5; k++) begin
            drive(32'h9988ccdd, 4'b1111, 1'b0);
            check("bp_hold_data", data_out, hold_val);
            check("bp_hold_valid", {31'd0, data_out_valid}, 32'd1);
        end
        drive(32'h9988ccdd, 4'b1111, 1'b1);
        drive(32'h0, 4'b0000, 1'b1);
        check("bp_release", data_out, ref_xfer(32'h9988ccdd, 4'b1111));

        // Asynchronous reset between edges with a pending result
        drive(32'h4455bb66, 4'b1011, 1'b1);
        drive(32'h0, 4'b0000, 1'b0);
        check("pre_rst_valid", {31'd0, data_out_valid}, 32'd1);
        #1;
        rst = 1'b1;
        exp_q.delete();
        model_vld = 1'b0;
        #1;
        check("arst_valid", {31'd0, data_out_valid}, 32'd0);
        check("arst_data", data_out, 32'd0);
        check("arst_ready", {31'd0, data_in_ready}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(32'h0, 4'b0000, 1'b1);
            check("post_rst_idle", {31'd0, data_out_valid}, 32'd0);
        end

        // Idle input with arbitrary data
        for (int k = 0; k < 10; k++) begin
            drive($urandom, 4'b0000, 1'($urandom_range(0, 1)));
            check("idle_valid", {31'd0, data_out_valid}, 32'd0);
        end

        // Randomized traffic with random backpressure
        for (int k = 0; k < 300; k++) begin
            logic [3:0] v;
            v = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom);
            drive($urandom, v, ($urandom_range(0, 9) < 7));
        end

        // Drain
        for (int k = 0; k < 4; k++) drive(32'h0, 4'b0000, 1'b1);
        check("drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
